// File: rtl/jtkunio_tilemap.sv
// jtkunio_tilemap
// ---------------
// Scrolling 16x16 tile-map layer. The block owns the tile VRAM, which is shared
// between a CPU port and the scan side. At every tile boundary it fetches the
// next tile's two 8-pixel halves from the ROM port and serialises the pixels to
// the colour mixer.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   pxl_cen        pixel clock enable
//   flip           global screen flip
//   h, v           beam counters
//   hscr, vscr     horizontal / vertical scroll
//   cpu_addr       CPU byte address (MSB selects the high byte of the tile entry)
//   scr_cs         VRAM chip select
//   cpu_wrn        active-low write strobe
//   cpu_dout       CPU write data
//   cpu_din        registered CPU read data
//   rom_cs         ROM request
//   rom_addr       {code, row, half}
//   rom_data       ROM word, plane p in bits [p*8+:8], bit 7 is the leftmost pixel
//   rom_ok         ROM data valid
//   pxl            {palette, colour}
//   underrun       sticky flag: a tile was not ready at its boundary
module jtkunio_tilemap #(
    parameter int COLSW   = 6,
    parameter int ROWSW   = 4,
    parameter int BPP     = 3,
    parameter int PALW    = 3,
    parameter int CODEW   = 11,
    parameter int HTOTAL  = 384,
    parameter int HOFFSET = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pxl_cen,
    input  logic                     flip,
    input  logic [8:0]               h,
    input  logic [7:0]               v,
    input  logic [COLSW+3:0]         hscr,
    input  logic [ROWSW+3:0]         vscr,
    input  logic [COLSW+ROWSW:0]     cpu_addr,
    input  logic                     scr_cs,
    input  logic                     cpu_wrn,
    input  logic [7:0]               cpu_dout,
    output logic [7:0]               cpu_din,
    output logic                     rom_cs,
    output logic [CODEW+4:0]         rom_addr,
    input  logic [31:0]              rom_data,
    input  logic                     rom_ok,
    output logic [PALW+BPP-1:0]      pxl,
    output logic                     underrun
);

    localparam int HW  = COLSW + 4;
    localparam int VW  = ROWSW + 4;
    localparam int AW  = COLSW + ROWSW;
    localparam int CHW = CODEW - 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_FETCH0 = 3'd2,
        ST_FETCH1 = 3'd3,
        ST_READY  = 3'd4
    } state_t;

    logic [7:0] vram_lo_r [0:(2**AW)-1];
    logic [7:0] vram_hi_r [0:(2**AW)-1];

    state_t              state_r;
    logic [7:0]          scan_lo_r;
    logic [7:0]          scan_hi_r;
    logic [PALW-1:0]     pal_nxt_r;
    logic                hflip_r;
    logic [31:0]         half0_r;
    logic [31:0]         half1_r;
    logic [PALW-1:0]     pal_r;
    logic                dir_r;
    logic [BPP-1:0][15:0] plane_r;

    logic [9:0]          hadv_raw_s;
    logic [9:0]          hadv_wrap_s;
    logic [8:0]          hadv_s;
    logic [15:0]         hsum_full_s;
    logic [HW-1:0]       hsum_s;
    logic [7:0]          vsel_s;
    logic [15:0]         vsum_full_s;
    logic [VW-1:0]       vsum_s;
    logic [AW-1:0]       map_addr_s;
    logic                boundary_s;
    logic [AW-1:0]       cpu_idx_s;
    logic                cpu_hi_s;
    logic [CODEW-1:0]    scan_code_s;
    logic [PALW-1:0]     scan_pal_s;
    logic                scan_hflip_s;
    logic                scan_vflip_s;
    logic [BPP-1:0]      head_s;
    logic [BPP-1:0][15:0] load_s;
    logic                unused_s;

    assign cpu_idx_s    = cpu_addr[AW-1:0];
    assign cpu_hi_s     = cpu_addr[AW];
    assign scan_pal_s   = scan_hi_r[7 -: PALW];
    assign scan_hflip_s = scan_hi_r[7-PALW];
    assign scan_vflip_s = scan_hi_r[6-PALW];
    assign unused_s     = ^{rom_data, scan_hi_r, hadv_wrap_s[9], hsum_full_s, vsum_full_s};

    // The upper code bits sit just below the flip bits in the high byte
    generate
        if (CHW > 0) begin : g_code_hi
            assign scan_code_s = {scan_hi_r[5-PALW -: CHW], scan_lo_r};
        end else begin : g_code_lo
            assign scan_code_s = scan_lo_r;
        end
    endgenerate

    // Beam-to-map position: fetch-ahead offset, line wrap, flip and scroll
    always_comb begin
        hadv_raw_s = {1'b0, h} + 10'(HOFFSET);
        if (hadv_raw_s >= 10'(HTOTAL)) begin
            hadv_wrap_s = hadv_raw_s - 10'(HTOTAL);
        end else begin
            hadv_wrap_s = hadv_raw_s;
        end
        hadv_s      = flip ? ~hadv_wrap_s[8:0] : hadv_wrap_s[8:0];
        hsum_full_s = 16'(hadv_s) + 16'(hscr);
        hsum_s      = hsum_full_s[HW-1:0];
        vsel_s      = flip ? ~v : v;
        vsum_full_s = 16'(vsel_s) + 16'(vscr);
        vsum_s      = vsum_full_s[VW-1:0];
        map_addr_s  = {vsum_s[VW-1:4], hsum_s[HW-1:4]};
        boundary_s  = pxl_cen && (hsum_s[3:0] == 4'd0);
    end

    // Shifter head and the 16-pixel load image (bit 15 is the leftmost pixel)
    always_comb begin
        head_s = '0;
        load_s = '0;
        for (int p = 0; p < BPP; p++) begin
            head_s[p] = dir_r ? plane_r[p][0] : plane_r[p][15];
            load_s[p] = {half0_r[p*8 +: 8], half1_r[p*8 +: 8]};
        end
    end

    // CPU writes into VRAM
    always_ff @(posedge clk) begin
        if (scr_cs && !cpu_wrn) begin
            if (cpu_hi_s) begin
                vram_hi_r[cpu_idx_s] <= cpu_dout;
            end else begin
                vram_lo_r[cpu_idx_s] <= cpu_dout;
            end
        end
    end

    // Registered CPU read-back
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_din <= 8'h00;
        end else begin
            cpu_din <= cpu_hi_s ? vram_hi_r[cpu_idx_s] : vram_lo_r[cpu_idx_s];
        end
    end

    // Scan-side VRAM read, consumed by the FSM one clk later in SCAN
    always_ff @(posedge clk) begin
        scan_lo_r <= vram_lo_r[map_addr_s];
        scan_hi_r <= vram_hi_r[map_addr_s];
    end

    // Pixel shifter: emit one pixel per enable, reload at every tile boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pxl     <= '0;
            pal_r   <= '0;
            dir_r   <= 1'b0;
            plane_r <= '0;
        end else if (pxl_cen) begin
            pxl <= {pal_r, head_s};
            if (boundary_s) begin
                if (state_r == ST_READY) begin
                    plane_r <= load_s;
                    pal_r   <= pal_nxt_r;
                    dir_r   <= hflip_r ^ flip;
                end else begin
                    // tile not fetched in time: draw it blank
                    plane_r <= '0;
                    pal_r   <= '0;
                    dir_r   <= 1'b0;
                end
            end else begin
                for (int p = 0; p < BPP; p++) begin
                    plane_r[p] <= dir_r ? {1'b0, plane_r[p][15:1]} : {plane_r[p][14:0], 1'b0};
                end
            end
        end
    end

    // Tile fetch FSM against the ROM port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            underrun  <= 1'b0;
            pal_nxt_r <= '0;
            hflip_r   <= 1'b0;
            half0_r   <= 32'h0000_0000;
            half1_r   <= 32'h0000_0000;
        end else if (boundary_s) begin
            // a boundary outside READY means the previous fetch lost the race;
            // from IDLE nothing was pending yet
            if (state_r != ST_READY && state_r != ST_IDLE) begin
                underrun <= 1'b1;
            end
            rom_cs  <= 1'b0;
            state_r <= ST_SCAN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rom_cs <= 1'b0;
                end
                ST_SCAN: begin
                    pal_nxt_r <= scan_pal_s;
                    hflip_r   <= scan_hflip_s;
                    rom_cs    <= 1'b1;
                    rom_addr  <= {scan_code_s, vsum_s[3:0] ^ {4{scan_vflip_s}}, scan_hflip_s};
                    state_r   <= ST_FETCH0;
                end
                ST_FETCH0: begin
                    if (rom_ok) begin
                        if (rom_addr[0]) begin
                            half1_r <= rom_data;
                        end else begin
                            half0_r <= rom_data;
                        end
                        rom_addr[0] <= ~rom_addr[0];
                        state_r     <= ST_FETCH1;
                    end
                end
                ST_FETCH1: begin
                    if (rom_ok) begin
                        if (rom_addr[0]) begin
                            half1_r <= rom_data;
                        end else begin
                            half0_r <= rom_data;
                        end
                        rom_cs  <= 1'b0;
                        state_r <= ST_READY;
                    end
                end
                ST_READY: begin
                    rom_cs <= 1'b0;
                end
                default: begin
                    rom_cs  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtkunio_tilemap.sv
// Testbench for jtkunio_tilemap: table of scroll/flip scenarios checked pixel by
// pixel against a tile-level model through an expected-pixel queue, plus hand
// sequences for reset, ROM handshake, flip, underrun and CPU read-back.
module tb_jtkunio_tilemap;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic        flip;
    logic [8:0]  h;
    logic [7:0]  v;
    logic [9:0]  hscr;
    logic [7:0]  vscr;
    logic [10:0] cpu_addr;
    logic        scr_cs;
    logic        cpu_wrn;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        rom_cs;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic [5:0]  pxl;
    logic        underrun;

    logic        rom_en;
    logic        rom_ovr;

    int nvec  = 0;
    int nfail = 0;

    logic [7:0] vram_lo_m [0:1023];
    logic [7:0] vram_hi_m [0:1023];
    logic [5:0] exp_q [$];

    typedef struct {
        logic [9:0] hscr;
        logic [7:0] vscr;
        logic [7:0] v;
        logic       flip;
        int         div;
        int         ncen;
        logic       exp_underrun;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    jtkunio_tilemap dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .flip     (flip),
        .h        (h),
        .v        (v),
        .hscr     (hscr),
        .vscr     (vscr),
        .cpu_addr (cpu_addr),
        .scr_cs   (scr_cs),
        .cpu_wrn  (cpu_wrn),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .pxl      (pxl),
        .underrun (underrun)
    );

    function automatic logic [31:0] rom_fn(input logic [15:0] a);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = a[7:0];
        hi = a[15:8];
        return {hi ^ 8'hC3, lo + 8'h11, lo ^ {a[4:0], a[15:13]}, hi + lo};
    endfunction

    assign rom_ok   = rom_cs & rom_en;
    assign rom_data = rom_ovr ? (rom_addr[0] ? 32'h0000_0000 : 32'h0000_0080) : rom_fn(rom_addr);

    // {pal, colour} shown at display column j of the tile at map index idx
    function automatic logic [5:0] tile_px(input int idx, input int vs, input logic flp, input int j);
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [3:0]  row;
        logic [14:0] base;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [2:0]  col;
        int          i;
        lo   = vram_lo_m[idx];
        hi   = vram_hi_m[idx];
        row  = 4'(vs) ^ {4{hi[3]}};
        base = {hi[2:0], lo, row};
        w0   = rom_fn({base, 1'b0});
        w1   = rom_fn({base, 1'b1});
        i    = (hi[4] ^ flp) ? 15 - j : j;
        for (int p = 0; p < 3; p++) begin
            col[p] = (i < 8) ? w0[p*8 + 7 - i] : w1[p*8 + 15 - i];
        end
        return {hi[7:5], col};
    endfunction

    function automatic int calc_hsum(input int hh, input int hs, input logic flp);
        int a;
        a = hh + 23;
        if (a >= 384) a = a - 384;
        if (flp) a = 511 - a;
        return (a + hs) % 1024;
    endfunction

    function automatic int calc_vsum(input int vv, input int vs, input logic flp);
        return ((flp ? 255 - vv : vv) + vs) % 256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
        scr_cs   = 1'b1;
        cpu_wrn  = 1'b0;
        cpu_addr = a;
        cpu_dout = d;
        tick();
        scr_cs   = 1'b0;
        cpu_wrn  = 1'b1;
        if (a[10]) vram_hi_m[a[9:0]] = d;
        else       vram_lo_m[a[9:0]] = d;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        pxl_cen = 1'b0;
        tick();
        rst     = 1'b0;
    endtask

    // Tile-level model of one scenario; expected pixels go through exp_q
    task automatic run_vec(input vec_t t, input int n);
        logic [2:0] m_col [16];
        logic [2:0] m_pal;
        int   m_k;
        logic m_idle;
        logic m_under;
        logic p_valid;
        int   p_idx;
        int   p_vs;
        int   hc;
        int   hs;
        int   vs;
        logic [5:0] e;
        logic [5:0] got;
        hscr = t.hscr;
        vscr = t.vscr;
        v    = t.v;
        flip = t.flip;
        do_reset();
        for (int j = 0; j < 16; j++) m_col[j] = 3'd0;
        m_pal = 3'd0; m_k = 16; m_idle = 1'b1; m_under = 1'b0;
        p_valid = 1'b0; p_idx = 0; p_vs = 0; hc = 0;
        vs = calc_vsum(int'(t.v), int'(t.vscr), t.flip);
        for (int c = 0; c < t.ncen; c++) begin
            for (int d = 1; d < t.div; d++) begin
                pxl_cen = 1'b0;
                tick();
            end
            pxl_cen = 1'b1;
            h  = 9'(hc);
            hs = calc_hsum(hc, int'(t.hscr), t.flip);
            e  = {m_pal, (m_k < 16) ? m_col[m_k] : 3'd0};
            exp_q.push_back(e);
            if ((hs % 16) == 0) begin
                if (p_valid) begin
                    for (int j = 0; j < 16; j++) begin
                        e = tile_px(p_idx, p_vs, t.flip, j);
                        m_col[j] = e[2:0];
                        m_pal    = e[5:3];
                    end
                end else begin
                    for (int j = 0; j < 16; j++) m_col[j] = 3'd0;
                    m_pal = 3'd0;
                    if (!m_idle) m_under = 1'b1;
                end
                m_idle  = 1'b0;
                m_k     = 0;
                p_valid = 1'b1;
                p_idx   = (vs / 16) * 64 + hs / 16;
                p_vs    = vs;
            end else begin
                m_k++;
            end
            tick();
            got = pxl;
            check($sformatf("vec%0d pxl c%0d", n, c), 32'(got), 32'(exp_q.pop_front()));
            hc = (hc + 1) % 384;
        end
        pxl_cen = 1'b0;
        check($sformatf("vec%0d underrun", n), 32'(underrun), 32'(t.exp_underrun & m_under));
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; flip = 1'b0; h = 9'd0; v = 8'd0;
        hscr = 10'd0; vscr = 8'd0; cpu_addr = 11'd0; scr_cs = 1'b0;
        cpu_wrn = 1'b1; cpu_dout = 8'h00; rom_en = 1'b1; rom_ovr = 1'b0;

        tbl[0] = '{hscr: 10'd0,    vscr: 8'd0,   v: 8'd0,   flip: 1'b0, div: 1, ncen: 400, exp_underrun: 1'b0};
        tbl[1] = '{hscr: 10'd1023, vscr: 8'd255, v: 8'd1,   flip: 1'b0, div: 1, ncen: 400, exp_underrun: 1'b0};
        tbl[2] = '{hscr: 10'd37,   vscr: 8'd17,  v: 8'd100, flip: 1'b0, div: 2, ncen: 200, exp_underrun: 1'b0};
        tbl[3] = '{hscr: 10'd200,  vscr: 8'd5,   v: 8'd50,  flip: 1'b1, div: 1, ncen: 400, exp_underrun: 1'b0};
        tbl[4] = '{hscr: 10'd1023, vscr: 8'd128, v: 8'd7,   flip: 1'b1, div: 2, ncen: 200, exp_underrun: 1'b0};

        tick(); tick();
        rst = 1'b0;
        check("reset pxl", 32'(pxl), 32'h0);
        check("reset rom_cs", 32'(rom_cs), 32'h0);
        check("reset rom_addr", 32'(rom_addr), 32'h0);
        check("reset cpu_din", 32'(cpu_din), 32'h0);
        check("reset underrun", 32'(underrun), 32'h0);

        // fill the whole map with pseudo-random entries
        for (int i = 0; i < 1024; i++) begin
            cpu_write({1'b0, 10'(i)}, 8'($urandom_range(255)));
            cpu_write({1'b1, 10'(i)}, 8'($urandom_range(255)));
        end

        // ROM handshake, mid-fetch reset and palette on a known entry
        cpu_write(11'h000, 8'h34);
        cpu_write(11'h400, 8'hA1);
        rom_en = 1'b0;
        do_reset();
        pxl_cen = 1'b1; h = 9'd361; tick();
        pxl_cen = 1'b0; tick();
        check("fetch0 rom_cs", 32'(rom_cs), 32'h1);
        check("fetch0 rom_addr", 32'(rom_addr), 32'h2680);
        tick(); tick();
        check("fetch0 hold addr", 32'(rom_addr), 32'h2680);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midfetch rst rom_cs", 32'(rom_cs), 32'h0);
        check("midfetch rst pxl", 32'(pxl), 32'h0);
        check("midfetch rst underrun", 32'(underrun), 32'h0);
        tick(); tick();
        check("idle after rst rom_cs", 32'(rom_cs), 32'h0);
        pxl_cen = 1'b1; h = 9'd361; tick();
        pxl_cen = 1'b0; tick();
        check("restart rom_addr", 32'(rom_addr), 32'h2680);
        rom_en = 1'b1; tick(); rom_en = 1'b0;
        check("fetch1 rom_cs", 32'(rom_cs), 32'h1);
        check("fetch1 rom_addr", 32'(rom_addr), 32'h2681);
        tick();
        check("fetch1 hold addr", 32'(rom_addr), 32'h2681);
        rom_en = 1'b1; tick();
        check("ready rom_cs", 32'(rom_cs), 32'h0);
        pxl_cen = 1'b1; h = 9'd361; tick();
        h = 9'd362; tick();
        pxl_cen = 1'b0;
        check("pal5 first pixel", 32'(pxl), 32'(tile_px(0, 0, 1'b0, 0)));
        check("pal5 field", 32'(pxl[5:3]), 32'd5);

        // hflip: natural pixel 0 must land in display column 15
        cpu_write(11'h400, 8'hB1);
        rom_ovr = 1'b1;
        do_reset();
        for (int k = 0; k <= 32; k++) begin
            pxl_cen = 1'b1; h = 9'((361 + k) % 384);
            if (k >= 17) exp_q.push_back({3'd5, (k == 32) ? 3'd1 : 3'd0});
            tick();
            if (k >= 17) check($sformatf("hflip col%0d", k - 17), 32'(pxl), 32'(exp_q.pop_front()));
        end
        pxl_cen = 1'b0;
        rom_ovr = 1'b0;

        // underrun: a stalled tile draws blank, the next one draws normally
        rom_en = 1'b0;
        do_reset();
        for (int k = 0; k <= 48; k++) begin
            pxl_cen = 1'b1; h = 9'((361 + k) % 384);
            if (k >= 17 && k <= 32) exp_q.push_back(6'd0);
            if (k >= 33) exp_q.push_back(tile_px(1, 0, 1'b0, k - 33));
            tick();
            if (k == 16) begin
                check("underrun set", 32'(underrun), 32'h1);
                check("abort rom_cs low", 32'(rom_cs), 32'h0);
                rom_en = 1'b1;
            end
            if (k == 17) check("refetch rom_cs", 32'(rom_cs), 32'h1);
            if (k >= 17) check($sformatf("underrun px%0d", k), 32'(pxl), 32'(exp_q.pop_front()));
        end
        pxl_cen = 1'b0;
        check("underrun sticky", 32'(underrun), 32'h1);
        do_reset();
        check("underrun cleared", 32'(underrun), 32'h0);

        // CPU read-back
        cpu_write(11'h405, 8'h5A);
        cpu_addr = 11'h405; tick();
        check("readback hi", 32'(cpu_din), 32'h5A);
        cpu_addr = 11'h000; tick();
        check("readback lo", 32'(cpu_din), 32'(vram_lo_m[0]));

        // scroll/flip scenario table
        for (int n = 0; n < 5; n++) begin
            run_vec(tbl[n], n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/jtkunio_tilemap.md
Name: jtkunio_tilemap

Overview:
- Parametrised tile-map scroll layer: 16x16 tiles, per-tile palette and H/V flip, independent H and V scroll, configurable map size, bit depth and line length.
- Owns the CPU-visible tile VRAM (dual port: CPU side plus scan side), runs a per-tile fetch FSM against the SDRAM ROM port with an rom_cs/rom_ok handshake, and serialises pixels to the colour mixer.
- Successor of the fixed single-layer scroll used in kunio; intended for reuse by later cores.

Parameters:
- COLSW, 6, log2 map columns (map is 2^COLSW tiles wide).
- ROWSW, 4, log2 map rows.
- BPP, 3, bits per pixel (1..4).
- PALW, 3, palette bits per tile.
- CODEW, 11, tile code width (8..11). Constraint: PALW+2+CODEW-8 <= 8.
- HTOTAL, 384, pixel count per line for h wrap.
- HOFFSET, 23, fetch-ahead offset added to h.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- pxl_cen  in  1  pixel clock enable
- flip  in  1  global screen flip
- h  in  9  horizontal counter
- v  in  8  vertical counter
- hscr  in  COLSW+4  horizontal scroll
- vscr  in  ROWSW+4  vertical scroll
- cpu_addr  in  COLSW+ROWSW+1  byte address; MSB 0 = low byte, 1 = high byte
- scr_cs  in  1  VRAM chip select
- cpu_wrn  in  1  write strobe, active low
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CPU read data, registered
- rom_cs  out  1  ROM request
- rom_addr  out  CODEW+5  {code, row[3:0], half}
- rom_data  in  32  plane p occupies bits [p*8+:8]; bit 7 is the leftmost pixel
- rom_ok  in  1  ROM data valid for the current rom_addr
- pxl  out  PALW+BPP  {pal, colour}
- underrun  out  1  sticky flag: a tile was not ready in time

Behaviour:
- Reset (clk edge with rst=1): pxl=0, rom_cs=0, rom_addr=0, cpu_din=0, underrun=0, FSM=IDLE, shifters cleared. Reset is honoured mid-fetch; any pending fetch is abandoned.
- Tile entry in VRAM: low byte = code[7:0]. High byte = {pal[PALW-1:0], hflip, vflip, code[CODEW-1:8]}, MSB-aligned.
- CPU access: the write occurs when scr_cs & ~cpu_wrn. cpu_din returns the byte at cpu_addr one clk later. CPU reads and writes never stall the scan side.
- Horizontal position:
  - hadv = h+HOFFSET, minus HTOTAL if the result is >= HTOTAL.
  - If flip, hadv is bit-inverted to 9 bits.
  - hsum = (hadv+hscr) mod 2^(COLSW+4).
- Vertical position: vsum = ((flip ? ~v : v) + vscr) mod 2^(ROWSW+4). Both scroll sums wrap silently.
- Map address = {vsum[ROWSW+3:4], hsum[COLSW+3:4]}.
- FSM (advances only on clk; entry conditions are qualified by pxl_cen where stated):
  - IDLE: go to SCAN when pxl_cen and hsum[3:0]==0.
  - SCAN: one clk VRAM read latency; latch the attribute bytes.
  - FETCH0: drive rom_cs=1 and rom_addr={code, vsum[3:0]^{4{vflip}}, hflip}. Hold both stable until rom_ok; on rom_ok latch the word and go to FETCH1.
  - FETCH1: same, with half bit inverted. On rom_ok latch the word, drop rom_cs, go to READY.
  - READY: wait for the next tile boundary.
- At each boundary (pxl_cen and hsum[3:0]==0):
  - If READY: load the 16-pixel shifter and the pal register, then restart at SCAN.
  - Otherwise: load zeros, set underrun, and restart the fetch for the new tile.
- Pixel order:
  - Shifter emits one pixel per pxl_cen.
  - Left-to-right when hflip^flip==0, otherwise reversed.
  - pxl is registered, so the first pixel of a tile appears one pxl_cen after its boundary.
- rom_ok arriving in IDLE, SCAN or READY is ignored.
- A new boundary during FETCHx aborts the fetch: rom_cs drops for one clk, then the FSM re-enters SCAN.

Test Plan:
- Reset during FETCH0 with rom_cs=1 -> next clk rom_cs=0, pxl=0, underrun=0; after release the fetch restarts at the next boundary.
- CPU writes 8'h34 at low 0 and 8'hA1 at high 0; scroll=0, v=0, flip=0 -> rom_addr=16'b001_0011_0100_0000_0 then the same address with half=1; pal=5.
- Tile at 0 with hflip=1, rom_data plane0=8'h80 (half 0 first) -> pixel colour 1 appears at the rightmost column (pixel 15), not column 0.
- hscr = 2^(COLSW+4)-1 with h sweeping the line -> map column index wraps from 63 to 0 with no glitch; vscr=255, v=1 -> vsum=0.
- rom_ok held low for a whole tile -> that tile outputs colour 0 and underrun stays 1 until reset; the next tile with rom_ok=1 draws normally.
- Read back: write 8'h5A to the high byte, then read -> cpu_din=8'h5A exactly one clk after the address is presented.
